led_cpu_with_rom: RTL and testbench
===================================

Name: led_cpu_with_rom

Overview:
- Tiny sequencer ("LED CPU") that steps through a hard-coded 256-entry instruction ROM.
- Each instruction drives an 8-bit LED pattern for 1–4 time ticks, then either falls through to the next address or jumps to an absolute address.
- A FREQ-controlled prescaler sets the tick rate; FREQ=0 gives one tick per clock.
- Sits directly in front of a board LED bank.

Parameters:
- FREQ, 0, prescaler terminal count; one tick every FREQ+1 clk cycles. 32-bit unsigned.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- outPattern  output  8  registered LED pattern of the currently executing instruction.

Behaviour:
- Internal program counter register named addrRd, 8 bits. It must keep this exact name: benches probe it hierarchically. It always holds the address of the instruction whose pattern is on outPattern.
- ROM word is 19 bits, combinational lookup on an address:
  - [18:11] pattern
  - [10:9] hold (ticks−1)
  - [8] jmp
  - [7:0] target
- ROM contents, as addr: pattern/hold-ticks/next:
  - 00: AA/1/+1
  - 01: 55/2/+1
  - 02: CC/3/+1
  - 03: 33/1/+1
  - 04: FF/3/+1
  - 05: 00/2/+1
  - 06: 0A/1/jmp 0A
  - 07–09: 00/1/jmp 00
  - 0A: 7F/2/+1
  - 0B: 80/1/+1
  - 0C: FF/1/+1
  - 0D: 00/2/+1
  - 0E: 11/3/+1
  - 0F: 00/1/jmp 00
  - 10–FF: 00/1/jmp 00
- Registers: addrRd[7:0], holdCnt[1:0], prescaler counter [31:0], outPattern[7:0].
- Reset (rst high at a rising edge): addrRd=00, holdCnt=0, prescaler=0, outPattern=ROM[00].pattern (AA). rst overrides everything on that edge.
- Tick generation: tick=1 when prescaler==FREQ. Prescaler is 0 on a tick edge, otherwise prescaler+1. With FREQ=0, tick is 1 every cycle.
- On a tick edge, when holdCnt < ROM[addrRd].hold: holdCnt increments; addrRd and outPattern are unchanged.
- On a tick edge, when holdCnt == ROM[addrRd].hold:
  - next = jmp ? target : addrRd+1, with 8-bit wrap (FF→00).
  - addrRd ← next; outPattern ← ROM[next].pattern; holdCnt ← 0.
  - The jump costs no extra cycle. The pattern at the target appears on the same edge that leaves the jumping instruction.
- Non-tick cycles: all state holds.
- outPattern changes only on rising clk edges; no combinational path from rst to the output.
- Hold range is 1–4 ticks; 0-tick instructions are impossible by encoding.

Test Plan:
- Reset/first step, FREQ=0, 10 ns clk: rst high through the 30 ns edge -> outPattern=AA, addrRd=00 while reset and until the 40 ns edge. Then 55 at 40 ns.
- Linear sequence: -> output change times and values:
  - 60 ns CC
  - 90 ns 33
  - 100 ns FF
  - 130 ns 00
  - 150 ns 0A
  - Each pattern held exactly its hold-tick count.
- Jump forward: 0A shown 1 cycle, then at 160 ns -> outPattern=7F and addrRd=0A.
- Second block: -> 80 at 180 ns, FF at 190, 00 at 200, 11 at 220, 00 at 250.
- Loop back: at 260 ns -> outPattern=AA and addrRd=00; sequence then repeats with identical timing.
- Prescaler and mid-run reset:
  - With FREQ=3, every hold duration scales by 4 (55 held 8 clocks).
  - Asserting rst mid-hold at addr 0E -> next edge outPattern=AA, addrRd=00, prescaler and holdCnt cleared.

Source files
------------

// File: rtl/led_cpu_with_rom.sv
// LED sequencer: steps a fixed 256-entry ROM, holding each 8-bit pattern for 1-4 ticks before
// falling through or jumping. FREQ sets the tick rate; the output is registered and has no backpressure.
module led_cpu_with_rom #(
  parameter logic [31:0] FREQ = 32'd0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] outPattern
);

  // The 19-bit ROM word is split into a pattern half [18:11] and a control half [10:0].
  // The control half is {hold (ticks-1), jmp, target}.
  function automatic logic [7:0] rom_pat(input logic [7:0] a);
    case (a)
      8'h00:   rom_pat = 8'hAA;
      8'h01:   rom_pat = 8'h55;
      8'h02:   rom_pat = 8'hCC;
      8'h03:   rom_pat = 8'h33;
      8'h04:   rom_pat = 8'hFF;
      8'h06:   rom_pat = 8'h0A;
      8'h0A:   rom_pat = 8'h7F;
      8'h0B:   rom_pat = 8'h80;
      8'h0C:   rom_pat = 8'hFF;
      8'h0E:   rom_pat = 8'h11;
      default: rom_pat = 8'h00;
    endcase
  endfunction

  function automatic logic [10:0] rom_ctl(input logic [7:0] a);
    case (a)
      8'h00:   rom_ctl = {2'd0, 1'b0, 8'h00};
      8'h01:   rom_ctl = {2'd1, 1'b0, 8'h00};
      8'h02:   rom_ctl = {2'd2, 1'b0, 8'h00};
      8'h03:   rom_ctl = {2'd0, 1'b0, 8'h00};
      8'h04:   rom_ctl = {2'd2, 1'b0, 8'h00};
      8'h05:   rom_ctl = {2'd1, 1'b0, 8'h00};
      8'h06:   rom_ctl = {2'd0, 1'b1, 8'h0A};
      8'h0A:   rom_ctl = {2'd1, 1'b0, 8'h00};
      8'h0B:   rom_ctl = {2'd0, 1'b0, 8'h00};
      8'h0C:   rom_ctl = {2'd0, 1'b0, 8'h00};
      8'h0D:   rom_ctl = {2'd1, 1'b0, 8'h00};
      8'h0E:   rom_ctl = {2'd2, 1'b0, 8'h00};
      default: rom_ctl = {2'd0, 1'b1, 8'h00};
    endcase
  endfunction

  logic [7:0]  addrRd;
  logic [1:0]  r_hold_cnt;
  logic [31:0] r_prescale;

  logic [10:0] w_ctl;
  logic [7:0]  w_next_addr;
  logic [7:0]  w_next_pat;
  logic        w_tick;

  assign w_ctl       = rom_ctl(addrRd);
  assign w_next_addr = w_ctl[8] ? w_ctl[7:0] : addrRd + 8'd1;
  assign w_next_pat  = rom_pat(w_next_addr);
  assign w_tick      = (r_prescale == FREQ);

  // The next pattern is loaded on the same edge that leaves the current instruction, so jumps are free.
  always_ff @(posedge clk) begin
    if (rst) begin
      addrRd     <= 8'h00;
      r_hold_cnt <= 2'd0;
      r_prescale <= 32'd0;
      outPattern <= 8'hAA;
    end else if (w_tick) begin
      r_prescale <= 32'd0;
      if (r_hold_cnt == w_ctl[10:9]) begin
        addrRd     <= w_next_addr;
        outPattern <= w_next_pat;
        r_hold_cnt <= 2'd0;
      end else begin
        r_hold_cnt <= r_hold_cnt + 2'd1;
      end
    end else begin
      r_prescale <= r_prescale + 32'd1;
    end
  end

endmodule

// File: tb/tb_led_cpu_with_rom.sv
// Bench for led_cpu_with_rom: two instances (FREQ=0 and FREQ=3) are checked against a
// scoreboard of expected (time, address, pattern) changes derived from the program listing.
module tb_led_cpu_with_rom;

  logic       clk;
  logic       rst0, rst3;
  logic [7:0] pat0, pat3;

  led_cpu_with_rom #(.FREQ(32'd0)) dut0 (.clk(clk), .rst(rst0), .outPattern(pat0));
  led_cpu_with_rom #(.FREQ(32'd3)) dut3 (.clk(clk), .rst(rst3), .outPattern(pat3));

  // Rising edges at 10, 20, 30 ... ns.
  initial begin
    clk = 1'b0;
    #10;
    forever begin
      clk = 1'b1; #5;
      clk = 1'b0; #5;
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  pat;
    int unsigned t;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One program loop starting after AA; ticks each entry is held.
  logic [7:0] seq_addr [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0A,
                                8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h00};
  logic [7:0] seq_pat  [13] = '{8'h55, 8'hCC, 8'h33, 8'hFF, 8'h00, 8'h0A, 8'h7F,
                                8'h80, 8'hFF, 8'h00, 8'h11, 8'h00, 8'hAA};
  int         seq_tick [13] = '{2, 3, 1, 3, 2, 1, 2, 1, 1, 2, 3, 1, 1};

  // r_edge: last reset edge; per: clocks per tick.
  task automatic push_seq(input int which, input int unsigned r_edge, input int per, input int loops);
    int unsigned cum;
    exp_t e;
    cum = 1;
    for (int l = 0; l < loops; l++) begin
      for (int k = 0; k < 13; k++) begin
        e.addr = seq_addr[k];
        e.pat  = seq_pat[k];
        e.t    = r_edge + 10 * per * cum;
        if (which == 0) q0.push_back(e); else q3.push_back(e);
        cum += seq_tick[k];
      end
    end
  endtask

  logic       armed;
  logic [7:0] last0, last3;

  always @(negedge clk) begin
    exp_t e;
    if (armed && dut0.addrRd !== last0) begin
      if (q0.size() == 0) begin
        chk("f0_unexpected_change", {24'd0, dut0.addrRd}, {24'd0, last0});
      end else begin
        e = q0.pop_front();
        chk("f0_addr", {24'd0, dut0.addrRd}, {24'd0, e.addr});
        chk("f0_pat",  {24'd0, pat0}, {24'd0, e.pat});
        chk("f0_time", int'($time) - 5, e.t);
      end
      last0 = dut0.addrRd;
    end
    if (armed && dut3.addrRd !== last3) begin
      if (q3.size() == 0) begin
        chk("f3_unexpected_change", {24'd0, dut3.addrRd}, {24'd0, last3});
      end else begin
        e = q3.pop_front();
        chk("f3_addr", {24'd0, dut3.addrRd}, {24'd0, e.addr});
        chk("f3_pat",  {24'd0, pat3}, {24'd0, e.pat});
        chk("f3_time", int'($time) - 5, e.t);
      end
      last3 = dut3.addrRd;
    end
  end

  initial begin
    exp_t e;
    armed = 1'b0;
    last0 = 8'h00;
    last3 = 8'h00;
    rst0  = 1'b1;
    rst3  = 1'b1;

    // Reset held through the 30 ns edge.
    #15;
    for (int i = 0; i < 3; i++) begin
      chk("rst_pat0",  {24'd0, pat0}, 32'hAA);
      chk("rst_addr0", {24'd0, dut0.addrRd}, 32'h0);
      chk("rst_pat3",  {24'd0, pat3}, 32'hAA);
      chk("rst_addr3", {24'd0, dut3.addrRd}, 32'h0);
      if (i < 2) #10;
    end
    chk("rst_presc3", dut3.r_prescale, 32'd0);
    chk("rst_hold3",  {30'd0, dut3.r_hold_cnt}, 32'd0);
    push_seq(0, 30, 1, 6);
    push_seq(3, 30, 4, 2);
    rst0  = 1'b0;
    rst3  = 1'b0;
    armed = 1'b1;

    // FREQ=3 instance sits on 0E from 790 to 910; reset it mid-hold at the 850 edge.
    #810;
    chk("pre_rst_pat3",  {24'd0, pat3}, 32'h11);
    chk("pre_rst_hold3", {30'd0, dut3.r_hold_cnt}, 32'd1);
    chk("pre_rst_presc3", dut3.r_prescale, 32'd1);
    rst3 = 1'b1;
    q3.delete();
    e.addr = 8'h00;
    e.pat  = 8'hAA;
    e.t    = 850;
    q3.push_back(e);
    push_seq(3, 850, 4, 2);
    #10;
    rst3 = 1'b0;
    chk("mid_rst_pat3",   {24'd0, pat3}, 32'hAA);
    chk("mid_rst_addr3",  {24'd0, dut3.addrRd}, 32'h0);
    chk("mid_rst_hold3",  {30'd0, dut3.r_hold_cnt}, 32'd0);
    chk("mid_rst_presc3", dut3.r_prescale, 32'd0);

    // Run on, then flag any expected change that never arrived.
    #540;
    armed = 1'b0;
    while (q0.size() > 0 && q0[0].t < 32'd1390) begin
      e = q0.pop_front();
      chk("f0_missed", 32'd0, e.t);
    end
    while (q3.size() > 0 && q3[0].t < 32'd1390) begin
      e = q3.pop_front();
      chk("f3_missed", 32'd0, e.t);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
